// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Purpose:
//   Merges the core's two SRAM-like channels (instruction fetch and data
//   load/store) onto one variable-latency memory bus. Only one transaction is
//   in flight at a time. Data has fixed priority over instruction. The
//   response is routed back to whichever channel issued the request.
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   inst_req/inst_addr     instruction read request (always a read)
//   inst_addr_ok           instruction request accepted this cycle
//   inst_data_ok           instruction read data valid this cycle
//   inst_rdata             last instruction read data
//   data_req/data_wr/data_wstrb/data_addr/data_wdata
//                          data load/store request
//   data_addr_ok           data request accepted this cycle
//   data_data_ok           load data valid or store complete this cycle
//   data_rdata             last load data
//   mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata
//                          memory-side request, held stable until mem_gnt
//   mem_gnt                memory accepts the request (mem_req & mem_gnt)
//   mem_rvalid/mem_rdata   memory response (read data or write ack)
//   dbg_state              current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
//
// Handshakes:
//   Core side: a request is accepted in the cycle *_addr_ok is high, which
//   happens only in IDLE and only for the granted channel; an ungranted
//   request must be held by the core. *_data_ok is a one-cycle pulse.
//   Memory side: mem_req with its payload is held stable until the cycle
//   mem_gnt is high; the response is the first mem_rvalid after that.
//   mem_gnt outside REQ and mem_rvalid outside RESP are ignored.
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [1:0]          dbg_state
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Captured request; drives the memory bus for the whole transaction.
    logic                r_wr;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_owner_data;   // 1 = data channel, 0 = instruction

    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;

    logic                w_take_data;
    logic                w_take_inst;
    logic                w_resp_fire;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and acceptance decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_take_data  = 1'b0;
        w_take_inst  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins a tie; the fetch stays pending until a data-free
                // IDLE cycle, so continuous data traffic can starve fetches.
                if (data_req) begin
                    w_take_data  = 1'b1;
                    w_next_state = S_REQ;
                end else if (inst_req) begin
                    w_take_inst  = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_resp_fire = (r_state == S_RESP) && mem_rvalid;

    // -------------------------------------------------------------------------
    // Request register. An instruction fetch is always a read with no strobes.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr         <= 1'b0;
            r_wstrb      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_owner_data <= 1'b0;
        end else if (w_take_data) begin
            r_wr         <= data_wr;
            r_wstrb      <= data_wstrb;
            r_addr       <= data_addr;
            r_wdata      <= data_wdata;
            r_owner_data <= 1'b1;
        end else if (w_take_inst) begin
            r_wr         <= 1'b0;
            r_wstrb      <= '0;
            r_addr       <= inst_addr;
            r_wdata      <= '0;
            r_owner_data <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Response data. Each channel keeps its last read value until its next
    // read response; a store ack leaves data_rdata untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else if (w_resp_fire) begin
            if (!r_owner_data) begin
                r_inst_rdata <= mem_rdata;
            end else if (!r_wr) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_addr_ok = w_take_data;
    assign inst_addr_ok = w_take_inst;

    assign data_data_ok = (r_state == S_DONE) &&  r_owner_data;
    assign inst_data_ok = (r_state == S_DONE) && !r_owner_data;

    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;

    assign mem_req      = (r_state == S_REQ);
    assign mem_wr       = r_wr;
    assign mem_wstrb    = r_wstrb;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;

    assign dbg_state    = r_state;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//
// Directed bench for sram_like_arbiter. Inputs change 2 ns after a rising
// edge and outputs are checked 1 ns after that, well clear of the edge.
// Expected values are written out by hand from the intended cycle behaviour.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic              inst_req = 1'b0;
    logic [31:0]       inst_addr = '0;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req = 1'b0;
    logic              data_wr = 1'b0;
    logic [3:0]        data_wstrb = '0;
    logic [31:0]       data_addr = '0;
    logic [31:0]       data_wdata = '0;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    sram_like_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Snapshot of both ok strobes of a channel pair, packed {inst, data}.
    function automatic logic [31:0] oks_addr();
        return {30'd0, inst_addr_ok, data_addr_ok};
    endfunction

    function automatic logic [31:0] oks_data();
        return {30'd0, inst_data_ok, data_data_ok};
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        // ---------------- reset state
        #12;
        chk("rst_state",     32'(dbg_state), 32'd0);
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_wr",    32'(mem_wr),    32'd0);
        chk("rst_mem_addr",  mem_addr,       32'h0);
        chk("rst_mem_wdata", mem_wdata,      32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_oks_data",  oks_data(),     32'd0);
        chk("rst_inst_rd",   inst_rdata,     32'h0);
        chk("rst_data_rd",   data_rdata,     32'h0);
        resetn = 1'b1;
        tick();

        // ---------------- single fetch, immediate grant
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_gnt = 1'b1;
        #1;
        chk("f_c0_addr_ok",  oks_addr(), 32'b10);
        chk("f_c0_mem_req",  32'(mem_req), 32'd0);
        tick();
        inst_req = 1'b0; inst_addr = 32'hFFFF_FFFF;
        #1;
        chk("f_c1_mem_req",  32'(mem_req), 32'd1);
        chk("f_c1_mem_addr", mem_addr,     32'h1C00_0000);
        chk("f_c1_mem_wr",   32'(mem_wr),  32'd0);
        chk("f_c1_addr_ok",  oks_addr(),   32'b00);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0280_0C0C;
        #1;
        chk("f_c2_mem_req",  32'(mem_req), 32'd0);
        chk("f_c2_data_ok",  oks_data(),   32'b00);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("f_c3_data_ok",  oks_data(),   32'b10);
        chk("f_c3_rdata",    inst_rdata,   32'h0280_0C0C);
        tick();
        #1;
        chk("f_c4_data_ok",  oks_data(),   32'b00);
        chk("f_c4_state",    32'(dbg_state), 32'd0);

        // ---------------- store, grant delayed 3 cycles
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
        data_addr = 32'h0000_1004; data_wdata = 32'hDEAD_BEEF;
        #1;
        chk("s_c0_addr_ok",  oks_addr(), 32'b01);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_gnt = 1'b1;
            #1;
            chk($sformatf("s_req%0d_mem_req", i),   32'(mem_req),   32'd1);
            chk($sformatf("s_req%0d_mem_wr", i),    32'(mem_wr),    32'd1);
            chk($sformatf("s_req%0d_mem_addr", i),  mem_addr,       32'h0000_1004);
            chk($sformatf("s_req%0d_mem_wdata", i), mem_wdata,      32'hDEAD_BEEF);
            chk($sformatf("s_req%0d_mem_wstrb", i), 32'(mem_wstrb), 32'h3);
            tick();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        #1;
        chk("s_resp_mem_req", 32'(mem_req), 32'd0);
        chk("s_resp_data_ok", oks_data(),   32'b00);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("s_done_data_ok", oks_data(),  32'b01);
        chk("s_done_data_rd", data_rdata,  32'h0);
        chk("s_done_inst_rd", inst_rdata,  32'h0280_0C0C);
        tick();
        #1;
        chk("s_idle_data_ok", oks_data(),  32'b00);

        // ---------------- simultaneous: load 0x2000 wins, fetch follows
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
        inst_req = 1'b1; inst_addr = 32'h1C00_0004; mem_gnt = 1'b1;
        #1;
        chk("b_c0_addr_ok",  oks_addr(), 32'b01);
        tick();
        data_req = 1'b0; data_addr = 32'h0;
        #1;
        chk("b_c1_mem_addr", mem_addr,     32'h0000_2000);
        chk("b_c1_mem_wr",   32'(mem_wr),  32'd0);
        chk("b_c1_addr_ok",  oks_addr(),   32'b00);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("b_c2_addr_ok",  oks_addr(),   32'b00);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("b_c3_data_ok",  oks_data(),   32'b01);
        chk("b_c3_data_rd",  data_rdata,   32'h1234_5678);
        chk("b_c3_addr_ok",  oks_addr(),   32'b00);
        tick();
        mem_gnt = 1'b1;
        #1;
        chk("b_c4_addr_ok",  oks_addr(),   32'b10);
        tick();
        inst_req = 1'b0; inst_addr = 32'h0;
        #1;
        chk("b_c5_mem_addr", mem_addr,     32'h1C00_0004);
        chk("b_c5_mem_req",  32'(mem_req), 32'd1);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0340_0000;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("b_c7_data_ok",  oks_data(),   32'b10);
        chk("b_c7_inst_rd",  inst_rdata,   32'h0340_0000);
        chk("b_c7_data_rd",  data_rdata,   32'h1234_5678);
        tick();

        // ---------------- reset while waiting in RESP
        inst_req = 1'b1; inst_addr = 32'h1C00_0008; mem_gnt = 1'b1;
        tick();
        inst_req = 1'b0;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("r_in_resp",     32'(dbg_state), 32'd2);
        resetn = 1'b0;
        #1;
        chk("r_async_state", 32'(dbg_state), 32'd0);
        chk("r_async_addr",  mem_addr,       32'h0);
        chk("r_async_irdat", inst_rdata,     32'h0);
        chk("r_async_drdat", data_rdata,     32'h0);
        tick();
        resetn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_rvalid = 1'b0;
            #1;
            chk($sformatf("r_after%0d_data_ok", i), oks_data(), 32'b00);
            chk($sformatf("r_after%0d_state", i), 32'(dbg_state), 32'd0);
        end
        // next request after reset proceeds normally
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000; mem_gnt = 1'b1;
        #1;
        chk("r_next_addr_ok", oks_addr(), 32'b01);
        tick();
        data_req = 1'b0;
        #1;
        chk("r_next_mem_addr", mem_addr, 32'h0000_3000);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("r_next_data_ok", oks_data(), 32'b01);
        chk("r_next_data_rd", data_rdata, 32'h0BAD_F00D);
        tick();

        // ---------------- stray rvalid / gnt in IDLE
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("x_state",   32'(dbg_state), 32'd0);
        chk("x_data_ok", oks_data(),     32'b00);
        chk("x_mem_req", 32'(mem_req),   32'd0);
        tick();
        #1;
        chk("x2_data_ok", oks_data(),    32'b00);
        chk("x2_inst_rd", inst_rdata,    32'h0);
        chk("x2_data_rd", data_rdata,    32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
